// File: rtl/pc_stack_unit_if.sv
// Command/status bundle between instruction decode and the PC/return-stack unit.
// The wrap member exists only when PC_WRAP_FLAG_EN is defined.
interface pc_stack_unit_if #(
   parameter int WIDTH       = 8,
   parameter int STACK_DEPTH = 4
);
   localparam int LVL_W = $clog2(STACK_DEPTH + 1);

   logic             en;
   logic             load;
   logic             call;
   logic             ret;
   logic [WIDTH-1:0] target;
   logic [WIDTH-1:0] pc;
   logic             stack_empty;
   logic             stack_full;
   logic [LVL_W-1:0] stack_level;
   logic             err;
`ifdef PC_WRAP_FLAG_EN
   logic             wrap;
`endif

   modport master (
`ifdef PC_WRAP_FLAG_EN
      input  wrap,
`endif
      output en, load, call, ret, target,
      input  pc, stack_empty, stack_full, stack_level, err
   );

   modport slave (
`ifdef PC_WRAP_FLAG_EN
      output wrap,
`endif
      input  en, load, call, ret, target,
      output pc, stack_empty, stack_full, stack_level, err
   );
endinterface

// File: rtl/pc_stack_unit.sv
// Program counter with STEP advance, jumps, and a LIFO return-address stack.
// Optional macro PC_WRAP_FLAG_EN adds a one-cycle wrap pulse after a carrying en-advance.
module pc_stack_unit #(
   parameter int               WIDTH        = 8,
   parameter int               STEP         = 1,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter int               STACK_DEPTH  = 4
) (
   input logic           clk,
   input logic           rst,
   pc_stack_unit_if.slave bus
);
   localparam int LVL_W = $clog2(STACK_DEPTH + 1);
   localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam logic [WIDTH:0]   STEP_EXT = (WIDTH + 1)'(STEP);
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(STACK_DEPTH);
   localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);

   typedef enum logic [2:0] {
      OP_HOLD,
      OP_EN,
      OP_LOAD,
      OP_CALL,
      OP_RET,
      OP_OFLOW,
      OP_UFLOW
   } op_t;

   op_t              op;
   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] pc_inc;
   logic             carry;
   logic [LVL_W-1:0] level_q;
   logic             err_q;
   logic             empty;
   logic             full;
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] rd_idx;
   logic [WIDTH-1:0] stack_mem [STACK_DEPTH];

   assign {carry, pc_inc} = {1'b0, pc_q} + STEP_EXT;
   assign empty  = (level_q == '0);
   assign full   = (level_q == LVL_FULL);
   // Push slot is the current level; the top entry sits one below it.
   assign wr_idx = level_q[IDX_W-1:0];
   assign rd_idx = IDX_W'(level_q - LVL_ONE);

   always_comb begin
      op = OP_HOLD;
      if (bus.ret)       op = empty ? OP_UFLOW : OP_RET;
      else if (bus.call) op = full ? OP_OFLOW : OP_CALL;
      else if (bus.load) op = OP_LOAD;
      else if (bus.en)   op = OP_EN;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q    <= RESET_VECTOR;
         level_q <= '0;
         err_q   <= 1'b0;
      end else begin
         case (op)
            OP_RET: begin
               pc_q    <= stack_mem[rd_idx];
               level_q <= level_q - LVL_ONE;
            end
            OP_CALL: begin
               pc_q    <= bus.target;
               level_q <= level_q + LVL_ONE;
            end
            OP_LOAD:            pc_q  <= bus.target;
            OP_EN:              pc_q  <= pc_inc;
            OP_OFLOW, OP_UFLOW: err_q <= 1'b1;
            default: ;
         endcase
      end
   end

   // Stack storage carries data only, so it is not reset.
   always_ff @(posedge clk) begin
      if (op == OP_CALL) stack_mem[wr_idx] <= pc_inc;
   end

`ifdef PC_WRAP_FLAG_EN
   logic wrap_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) wrap_q <= 1'b0;
      else     wrap_q <= (op == OP_EN) && carry;
   end

   assign bus.wrap = wrap_q;
`endif

   assign bus.pc          = pc_q;
   assign bus.stack_level = level_q;
   assign bus.stack_empty = empty;
   assign bus.stack_full  = full;
   assign bus.err         = err_q;
endmodule

// File: tb/tb_pc_stack_unit.sv
// Randomized and directed self-checking bench for pc_stack_unit against a queue-based model.
module tb_pc_stack_unit;
   localparam int         WIDTH = 8;
   localparam int         STEP  = 1;
   localparam logic [7:0] RV    = 8'h10;
   localparam int         DEPTH = 4;
   localparam int         MODV  = 1 << WIDTH;

   logic clk = 1'b0;
   logic rst = 1'b1;

   pc_stack_unit_if #(.WIDTH(WIDTH), .STACK_DEPTH(DEPTH)) bus ();

   pc_stack_unit #(
      .WIDTH(WIDTH), .STEP(STEP), .RESET_VECTOR(RV), .STACK_DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   int pc_m;
   int stk_m[$];
   bit err_m;
   bit wrap_m;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      pc_m   = int'(RV);
      err_m  = 1'b0;
      wrap_m = 1'b0;
      stk_m.delete();
   endtask

   task automatic model_step(input bit e, input bit l, input bit c, input bit r, input int t);
      wrap_m = 1'b0;
      if (r) begin
         if (stk_m.size() == 0) err_m = 1'b1;
         else pc_m = stk_m.pop_back();
      end else if (c) begin
         if (stk_m.size() == DEPTH) err_m = 1'b1;
         else begin
            stk_m.push_back((pc_m + STEP) % MODV);
            pc_m = t;
         end
      end else if (l) begin
         pc_m = t;
      end else if (e) begin
         wrap_m = (pc_m + STEP) >= MODV;
         pc_m   = (pc_m + STEP) % MODV;
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".pc"},    32'(bus.pc),          32'(pc_m));
      check({tag, ".lvl"},   32'(bus.stack_level), 32'(stk_m.size()));
      check({tag, ".empty"}, 32'(bus.stack_empty), 32'(stk_m.size() == 0));
      check({tag, ".full"},  32'(bus.stack_full),  32'(stk_m.size() == DEPTH));
      check({tag, ".err"},   32'(bus.err),         32'(err_m));
`ifdef PC_WRAP_FLAG_EN
      check({tag, ".wrap"},  32'(bus.wrap),        32'(wrap_m));
`endif
   endtask

   task automatic apply(input string tag, input bit e, input bit l, input bit c, input bit r,
                        input logic [7:0] t);
      bus.en     = e;
      bus.load   = l;
      bus.call   = c;
      bus.ret    = r;
      bus.target = t;
      @(posedge clk);
      model_step(e, l, c, r, int'(t));
      #1;
      check_outputs(tag);
   endtask

   // Reset asserted mid-cycle must take effect before the next clock edge.
   task automatic async_reset(input string tag);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_outputs(tag);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      bus.en = 0; bus.load = 0; bus.call = 0; bus.ret = 0; bus.target = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs("reset");
      @(negedge clk);
      rst = 1'b0;

      // Reset vector and increment
      for (int i = 0; i < 3; i++) apply("t1_en", 1, 0, 0, 0, 8'h00);
      check("t1_pc13", 32'(bus.pc), 32'h13);
      async_reset("t1_async");

      // Wrap-around
      apply("t2_load", 0, 1, 0, 0, 8'hFE);
      for (int i = 0; i < 3; i++) apply("t2_en", 1, 0, 0, 0, 8'h00);
      check("t2_pc01", 32'(bus.pc), 32'h01);

      // Call/return nesting
      apply("t3_load", 0, 1, 0, 0, 8'h20);
      apply("t3_call1", 0, 0, 1, 0, 8'h40);
      apply("t3_en", 1, 0, 0, 0, 8'h00);
      apply("t3_call2", 0, 0, 1, 0, 8'h60);
      apply("t3_ret1", 0, 0, 0, 1, 8'h00);
      check("t3_pc42", 32'(bus.pc), 32'h42);
      apply("t3_ret2", 0, 0, 0, 1, 8'h00);
      check("t3_pc21", 32'(bus.pc), 32'h21);

      // Overflow
      for (int i = 0; i < DEPTH; i++) apply("t4_call", 0, 0, 1, 0, 8'h80 + 8'(i * 8));
      apply("t4_oflow", 0, 0, 1, 0, 8'hAA);
      check("t4_err", 32'(bus.err), 32'h1);
      for (int i = 0; i < DEPTH; i++) apply("t4_ret", 0, 0, 0, 1, 8'h00);
      async_reset("t4_rst");

      // Underflow and priority
      apply("t5_uflow", 0, 0, 0, 1, 8'h00);
      apply("t5_prio_call", 1, 1, 1, 0, 8'h33);
      check("t5_pc33", 32'(bus.pc), 32'h33);
      apply("t5_prio_ret", 0, 0, 1, 1, 8'h55);
      check("t5_pc11", 32'(bus.pc), 32'h11);

      // Reset mid-operation
      for (int i = 0; i < 3; i++) apply("t6_call", 0, 0, 1, 0, 8'hC0);
      async_reset("t6_rst");
      apply("t6_uflow", 0, 0, 0, 1, 8'h00);

      // Random traffic with occasional asynchronous resets
      for (int i = 0; i < 400; i++) begin
         bit e, l, c, r;
         logic [7:0] t;
         e = ($urandom_range(0, 99) < 60);
         l = ($urandom_range(0, 99) < 10);
         c = ($urandom_range(0, 99) < 20);
         r = ($urandom_range(0, 99) < 18);
         t = ($urandom_range(0, 3) == 0) ? 8'(8'hFC + $urandom_range(0, 3)) : 8'($urandom);
         apply("rnd", e, l, c, r, t);
         if ($urandom_range(0, 59) == 0) async_reset("rnd_rst");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
Parametrised program-counter unit, the successor to the fixed-width PC incrementer. It holds the CPU program counter and advances it by a configurable step. It supports absolute jumps, subroutine call/return through an internal return-address stack, and hold (stall). It sits between instruction decode and instruction-memory address, and drives the fetch address every cycle.

Parameters:
WIDTH, 8, PC / address width in bits (>=4)
STEP, 1, increment applied on advance (1..2^WIDTH-1)
RESET_VECTOR, 0, PC value loaded on reset (WIDTH bits)
STACK_DEPTH, 4, return-address stack entries (>=1)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  advance PC by STEP this cycle
load  in  1  absolute jump: PC <= target
call  in  1  push return address, PC <= target
ret  in  1  pop return address into PC
target  in  WIDTH  jump/call destination
pc  out  WIDTH  current program counter (registered)
stack_empty  out  1  no entries on stack
stack_full  out  1  STACK_DEPTH entries on stack
stack_level  out  clog2(STACK_DEPTH+1)  current entry count
err  out  1  sticky stack overflow/underflow flag

Behaviour:
- Reset (async, any time, including mid call/ret): pc=RESET_VECTOR, stack_level=0, stack_empty=1, stack_full=0, err=0. Stack contents are don't-care. The first edge after rst deasserts applies normal priority.
- All outputs are registered. A command sampled at edge N is visible on pc after edge N, i.e. one-cycle latency.
- Priority per cycle, highest first: ret, call, load, en, hold. Lower-priority commands asserted in the same cycle are ignored, with no side effects.
- ret, stack not empty: pc <= top entry, stack_level-1.
- ret, stack empty: underflow. pc holds, stack unchanged, err <= 1.
- call, stack not full: push (pc + STEP) mod 2^WIDTH, pc <= target, stack_level+1.
- call, stack full: overflow. No push, pc holds, err <= 1.
- load: pc <= target; stack untouched.
- en: pc <= (pc + STEP) mod 2^WIDTH. Wrap-around is silent (e.g. WIDTH=8, STEP=1: 8'hFF -> 8'h00).
- None asserted: pc holds (stall).
- err is sticky and is cleared only by rst.
- stack_empty = (stack_level==0) and stack_full = (stack_level==STACK_DEPTH), both derived from the registered level.
- Stack is LIFO. Storage is a register array indexed by stack_level; no memory inference is required.
- The return-address addition is WIDTH-bit and truncates; the carry is discarded.

Optional Feature:
Macro PC_WRAP_FLAG_EN.
- Defined: adds output port wrap (1 bit, registered, reset 0). It pulses high for exactly one cycle after an en-advance whose pc + STEP carried out of WIDTH bits. A call that computes a wrapped return address does not pulse wrap.
- Not defined: port absent; wrap logic is not synthesised. All other behaviour is identical.

Test Plan:
1. Reset vector and increment: RESET_VECTOR=8'h10, rst pulse, en=1 for 3 cycles -> pc 8'h10, 11, 12, 13. Assert rst asynchronously mid-cycle -> pc=8'h10 immediately, before the next edge.
2. Wrap-around: load target=8'hFE, then en for 3 cycles -> pc FE, FF, 00, 01. With PC_WRAP_FLAG_EN defined, wrap is high only in the cycle after FF->00.
3. Call/return nesting: pc=8'h20; call target=8'h40; en; call target=8'h60; ret; ret -> pc 40, 41, 60, 42, 21. stack_level goes 1, 1, 2, 1, 0, and stack_empty=1 at the end.
4. Overflow: STACK_DEPTH=4. 4 calls fill the stack (stack_full=1). A 5th call with target=8'hAA -> pc unchanged, stack_level=4, err=1. Four rets then return correctly; err stays 1.
5. Underflow and priority: with the stack empty, ret -> pc holds, err=1. Then assert call+load+en together with target=8'h33 -> call wins: pc=8'h33, stack_level=1. Then ret+call together -> ret wins: pc = pushed address, stack_level=0.
6. Reset mid-operation: stack_level=3, assert rst -> stack_level=0, err=0, pc=RESET_VECTOR. Then a ret -> underflow, err=1.
